dbus_req_buffer: RTL and testbench



---
 rtl/dbus_req_buffer_if.sv | 29 ++
 rtl/dbus_req_buffer.sv | 76 +++++++
 tb/tb_dbus_req_buffer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dbus_req_buffer_if.sv
// dbus_req_buffer_if: dbus request/response types and the handshake bundle between pipeline, buffer and cache.
package dbus_pkg;
    typedef logic [2:0] msize_t;
    localparam msize_t MSIZE1 = 3'd0;
    localparam msize_t MSIZE2 = 3'd1;
    localparam msize_t MSIZE4 = 3'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

interface dbus_req_buffer_if;
    import dbus_pkg::*;
    dbus_req_t  req;
    dbus_resp_t resp;
    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/dbus_req_buffer.sv
// dbus_req_buffer: registered dbus request buffer with in-order response return and flush kill tracking.
// Optional DBUS_REQ_BYPASS_EN drives an idle-cycle request straight onto the cache port.
module dbus_req_buffer
    import dbus_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    dbus_req_buffer_if.slave         m,
    dbus_req_buffer_if.master        c,
    output logic                     busy
);
    logic             req_v;
    dbus_req_t        req_q;
    logic [CNT_W-1:0] out_cnt, kill_cnt, pend, inc, cnt_next, kill_next;
    logic             data_ok, issue_q, byp_issue, issue, room, accept, load;

    assign data_ok = c.resp.data_ok;
    assign issue_q = req_v && c.resp.addr_ok;
    assign pend    = out_cnt + CNT_W'(req_v);
    assign room    = pend < CNT_W'(DEPTH) || (pend == CNT_W'(DEPTH) && data_ok);
    assign accept  = resetn && m.req.valid && (!req_v || issue_q) && room && !flush;

`ifdef DBUS_REQ_BYPASS_EN
    logic byp;
    assign byp       = !req_v && out_cnt < CNT_W'(DEPTH) && !flush;
    assign byp_issue = byp && accept && c.resp.addr_ok;
    always_comb begin
        c.req       = byp ? m.req : req_q;
        c.req.valid = resetn && (byp ? m.req.valid : req_v);
    end
`else
    assign byp_issue = 1'b0;
    always_comb begin
        c.req       = req_q;
        c.req.valid = req_v;
    end
`endif

    assign issue = issue_q || byp_issue;
    assign load  = accept && !byp_issue;

    // a stray data_ok with nothing outstanding saturates at zero
    assign inc       = out_cnt + CNT_W'(issue);
    assign cnt_next  = inc - CNT_W'(data_ok && inc != '0);
    assign kill_next = flush ? cnt_next : kill_cnt - CNT_W'(data_ok && kill_cnt != '0);

    always_comb begin
        m.resp.addr_ok = accept;
        m.resp.data_ok = resetn && data_ok && kill_cnt == '0 && !flush;
        m.resp.data    = resetn ? c.resp.data : '0;
    end

    assign busy = req_v || out_cnt != '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_v    <= 1'b0;
            req_q    <= '0;
            out_cnt  <= '0;
            kill_cnt <= '0;
        end else begin
            req_v    <= load || (req_v && !issue_q && !flush);
            out_cnt  <= cnt_next;
            kill_cnt <= kill_next;
            if (load) req_q <= m.req;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) assert (!(data_ok && out_cnt == '0 && !issue));
    end
endmodule

// File: tb/tb_dbus_req_buffer.sv
// tb_dbus_req_buffer: directed plus random stimulus checked against a queue-based transaction model.
module tb_dbus_req_buffer;
    import dbus_pkg::*;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic flush = 1'b0;
    logic busy;
    dbus_req_buffer_if mi ();
    dbus_req_buffer_if ci ();

    dbus_req_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .m(mi), .c(ci), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int max_out = 0;
    bit kq[$];
    bit held_v = 1'b0;
    dbus_req_t held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: compare everything at the negedge, then advance the transaction model
    task automatic step();
        bit iss, dok, rm, acc, exp_dok;
        int sz, kills;
        @(negedge clk);
        sz    = kq.size();
        kills = 0;
        foreach (kq[i]) kills += int'(kq[i]);
        iss = held_v && ci.resp.addr_ok;
        dok = ci.resp.data_ok;
        rm  = (sz + int'(held_v) < DEPTH) || (sz + int'(held_v) == DEPTH && dok);
        acc = mi.req.valid && (!held_v || iss) && rm && !flush;
        exp_dok = dok && !flush && sz > 0 && !kq[0];
        chk("m_addr_ok", 32'(mi.resp.addr_ok), 32'(acc));
        chk("m_data_ok", 32'(mi.resp.data_ok), 32'(exp_dok));
        chk("m_data", mi.resp.data, ci.resp.data);
        chk("c_valid", 32'(ci.req.valid), 32'(held_v));
        if (held_v) begin
            chk("c_addr", ci.req.addr, held.addr);
            chk("c_wdata", ci.req.data, held.data);
            chk("c_strobe", 32'(ci.req.strobe), 32'(held.strobe));
            chk("c_size", 32'(ci.req.size), 32'(held.size));
        end
        chk("busy", 32'(busy), 32'(held_v || sz != 0));
        chk("out_cnt", 32'(dut.out_cnt), 32'(sz));
        chk("kill_cnt", 32'(dut.kill_cnt), 32'(kills));
        if (int'(dut.out_cnt) > max_out) max_out = int'(dut.out_cnt);
        if (dok && sz > 0) void'(kq.pop_front());
        if (iss) kq.push_back(1'b0);
        if (flush) foreach (kq[i]) kq[i] = 1'b1;
        if (flush) held_v = 1'b0;
        else if (acc) begin
            held_v = 1'b1;
            held   = mi.req;
        end else if (iss) held_v = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [31:0] addr, input logic ca, input logic cd,
                         input logic [31:0] cdata, input logic fl);
        mi.req.valid   = mv;
        mi.req.addr    = addr;
        mi.req.size    = MSIZE4;
        mi.req.strobe  = 4'($urandom);
        mi.req.data    = $urandom;
        ci.resp.addr_ok = ca;
        ci.resp.data_ok = cd && kq.size() > 0;
        ci.resp.data    = cdata;
        flush = fl;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) drive(1'b0, 32'h0, 1'b1, 1'b1, $urandom, 1'b0);
    endtask

    initial begin
        mi.req  = '0;
        ci.resp = '0;
        #12;
        chk("rst_c_valid", 32'(ci.req.valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        // single load
        drive(1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("single_busy_done", 32'(busy), 32'h0);
        // backpressure
        drive(1'b1, 32'h1000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h2000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h2000_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        drain();
        // depth limit
        for (int i = 0; i < 10; i++) drive(i < 8, 32'h3000_0000 + 32'(i * 4), 1'b1, i >= 6, $urandom, 1'b0);
        drain();
        // flush with one in flight and one pending, then flush on issue, then repeated flush
        drive(1'b1, 32'h4000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h4000_0004, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
        drive(1'b1, 32'h5000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("flush_issue_kill", 32'(dut.kill_cnt), 32'h1);
        drive(1'b1, 32'h5000_0010, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h5000_0020, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        drain();
        drive(1'b1, 32'h6000_0000, 1'b1, 1'b0, 32'h0, 1'b0);
        drain();
        // async reset with out_cnt=1 and req_v=1
        drive(1'b1, 32'h7000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h7000_0004, 1'b1, 1'b0, 32'h0, 1'b0);
        mi.req.valid    = 1'b1;
        ci.resp.data_ok = 1'b1;
        ci.resp.data    = 32'hCAFE_F00D;
        #2 resetn = 1'b0;
        #1;
        chk("arst_c_valid", 32'(ci.req.valid), 32'h0);
        chk("arst_addr_ok", 32'(mi.resp.addr_ok), 32'h0);
        chk("arst_data_ok", 32'(mi.resp.data_ok), 32'h0);
        chk("arst_data", mi.resp.data, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        kq.delete();
        held_v = 1'b0;
        mi.req  = '0;
        ci.resp = '0;
        #4 resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_out_cnt", 32'(dut.out_cnt), 32'h0);
        chk("arst_kill_cnt", 32'(dut.kill_cnt), 32'h0);
        // random traffic
        for (int i = 0; i < 800; i++)
            drive($urandom_range(9) < 6, $urandom, 1'($urandom), $urandom_range(9) < 4, $urandom,
                  $urandom_range(24) == 0);
        drain();
        chk("max_out_le_depth", 32'(max_out <= DEPTH), 32'h1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
